// File: rtl/seq_timing_ctrl.sv
// Sequence-counter controller for the Basic Computer timing chain: owns SC,
// the start/stop flip-flop S and the interrupt-cycle flip-flop R.
module seq_timing_ctrl #(
  parameter int T_LIMIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        hlt,
  input  logic        sc_clr,
  input  logic        int_req,
  output logic [3:0]  sc,
  output logic [15:0] t,
  output logic        s_run,
  output logic        r_int,
  output logic        fetch,
  output logic        decode,
  output logic        int_cycle,
  output logic        wrap_err
);

  localparam logic [3:0] LIMIT = 4'(T_LIMIT);

  logic [3:0] sc_q, sc_d;
  logic       s_q, s_d;
  logic       r_q, r_d;
  logic       werr_q, werr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q   <= '0;
      s_q    <= 1'b0;
      r_q    <= 1'b0;
      werr_q <= 1'b0;
    end else begin
      sc_q   <= sc_d;
      s_q    <= s_d;
      r_q    <= r_d;
      werr_q <= werr_d;
    end
  end

  always_comb begin
    s_d    = s_q;
    sc_d   = sc_q;
    r_d    = r_q;
    werr_d = werr_q;

    if (hlt)        s_d = 1'b0;
    else if (start) s_d = 1'b1;

    // SC priority chain; hlt leaves R untouched so a pending interrupt survives.
    if (hlt) begin
      sc_d = '0;
    end else if (!s_q) begin
      sc_d = sc_q;
    end else if (r_q && (sc_q == 4'd2)) begin
      sc_d = '0;
      r_d  = 1'b0;
    end else if (sc_clr) begin
      sc_d = '0;
    end else if (sc_q == LIMIT) begin
      sc_d   = '0;
      werr_d = 1'b1;
    end else begin
      sc_d = sc_q + 4'd1;
    end

    // Interrupt is latched mid-instruction so the next boundary enters RT0.
    if (s_q && !r_q && (sc_q >= 4'd3) && int_req) r_d = 1'b1;
  end

  assign sc        = sc_q;
  assign s_run     = s_q;
  assign r_int     = r_q;
  assign wrap_err  = werr_q;
  assign t         = s_q ? (16'd1 << sc_q) : 16'd0;
  assign fetch     = s_q && !r_q && (sc_q < 4'd2);
  assign decode    = s_q && !r_q && (sc_q == 4'd2);
  assign int_cycle = s_q && r_q && (sc_q < 4'd3);

endmodule

// File: tb/tb_seq_timing_ctrl.sv
// Bench for seq_timing_ctrl: two instances (T_LIMIT 15 and 7) share stimulus
// and are compared every cycle against a rule-level model.
module tb_seq_timing_ctrl;

  logic clk = 1'b0;
  logic rst, start, hlt, sc_clr, int_req;

  logic [3:0]  sc_w  [2];
  logic [15:0] t_w   [2];
  logic        s_w   [2];
  logic        r_w   [2];
  logic        f_w   [2];
  logic        d_w   [2];
  logic        ic_w  [2];
  logic        we_w  [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_timing_ctrl #(.T_LIMIT(15)) u_a (
    .clk(clk), .rst(rst), .start(start), .hlt(hlt), .sc_clr(sc_clr),
    .int_req(int_req), .sc(sc_w[0]), .t(t_w[0]), .s_run(s_w[0]),
    .r_int(r_w[0]), .fetch(f_w[0]), .decode(d_w[0]), .int_cycle(ic_w[0]),
    .wrap_err(we_w[0]));

  seq_timing_ctrl #(.T_LIMIT(7)) u_b (
    .clk(clk), .rst(rst), .start(start), .hlt(hlt), .sc_clr(sc_clr),
    .int_req(int_req), .sc(sc_w[1]), .t(t_w[1]), .s_run(s_w[1]),
    .r_int(r_w[1]), .fetch(f_w[1]), .decode(d_w[1]), .int_cycle(ic_w[1]),
    .wrap_err(we_w[1]));

  // Reference model state per instance
  int m_sc [2];
  bit m_s  [2];
  bit m_r  [2];
  bit m_we [2];
  int m_lim [2] = '{15, 7};
  bit m_valid = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_sc[k] = 0; m_s[k] = 0; m_r[k] = 0; m_we[k] = 0;
      end else begin
        bit ns, nr, nwe;
        int nsc;
        ns  = hlt ? 1'b0 : (start ? 1'b1 : m_s[k]);
        nr  = m_r[k];
        nwe = m_we[k];
        nsc = m_sc[k];
        if (hlt) nsc = 0;
        else if (m_s[k]) begin
          if (m_r[k] && m_sc[k] == 2) begin nsc = 0; nr = 0; end
          else if (sc_clr) nsc = 0;
          else if (m_sc[k] == m_lim[k]) begin nsc = 0; nwe = 1; end
          else nsc = m_sc[k] + 1;
        end
        if (m_s[k] && !m_r[k] && m_sc[k] >= 3 && int_req) nr = 1;
        m_s[k] = ns; m_r[k] = nr; m_we[k] = nwe; m_sc[k] = nsc;
      end
    end
    if (rst) m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        logic [15:0] et;
        et = m_s[k] ? (16'd1 << m_sc[k]) : 16'd0;
        check($sformatf("model_sc%0d", k), {12'd0, sc_w[k]}, 16'(m_sc[k]));
        check($sformatf("model_t%0d", k), t_w[k], et);
        check($sformatf("model_flags%0d", k),
              {10'd0, s_w[k], r_w[k], f_w[k], d_w[k], ic_w[k], we_w[k]},
              {10'd0, m_s[k], m_r[k], m_s[k] && !m_r[k] && m_sc[k] < 2,
               m_s[k] && !m_r[k] && m_sc[k] == 2, m_s[k] && m_r[k] && m_sc[k] < 3,
               m_we[k]});
      end
    end
  end

  // Apply inputs at a falling edge and advance one full cycle.
  task automatic tick(input bit st, input bit h, input bit c, input bit ir);
    start = st; hlt = h; sc_clr = c; int_req = ir;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit ir);
    for (int i = 0; i < n; i++) tick(0, 0, 0, ir);
  endtask

  initial begin
    rst = 1'b1; start = 0; hlt = 0; sc_clr = 0; int_req = 0;
    @(negedge clk); #1;
    check("rst_sc", {12'd0, sc_w[0]}, 16'd0);
    check("rst_t", t_w[0], 16'h0000);
    check("rst_flags", {12'd0, s_w[0], r_w[0], we_w[0], f_w[0]}, 16'd0);
    rst = 1'b0;

    // Start and free-run through the first timing states
    tick(1, 0, 0, 0);
    check("t0", t_w[0], 16'h0001); check("fetch0", {15'd0, f_w[0]}, 16'd1);
    idle(1, 0);
    check("t1", t_w[0], 16'h0002); check("fetch1", {15'd0, f_w[0]}, 16'd1);
    idle(1, 0);
    check("t2", t_w[0], 16'h0004); check("decode2", {15'd0, d_w[0]}, 16'd1);
    check("fetch2", {15'd0, f_w[0]}, 16'd0);
    idle(1, 0); check("t3", t_w[0], 16'h0008);
    idle(1, 0); check("t4", t_w[0], 16'h0010);
    idle(2, 0); check("sc6", {12'd0, sc_w[0]}, 16'd6);
    tick(0, 0, 1, 0);
    check("clr_t", t_w[0], 16'h0001); check("clr_werr", {15'd0, we_w[0]}, 16'd0);
    idle(4, 0); check("sc4", {12'd0, sc_w[0]}, 16'd4);
    tick(0, 1, 0, 0);
    check("hlt_t", t_w[0], 16'h0000); check("hlt_s", {15'd0, s_w[0]}, 16'd0);
    idle(3, 0);
    check("hlt_hold_sc", {12'd0, sc_w[0]}, 16'd0); check("hlt_hold_t", t_w[0], 16'h0000);

    // Interrupt latched at T3, serviced after the clear
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 1);
    check("ir_sc1_r", {15'd0, r_w[0]}, 16'd0);
    idle(2, 1);
    check("ir_sc3_r", {15'd0, r_w[0]}, 16'd0);
    idle(1, 1);
    check("ir_set_r", {15'd0, r_w[0]}, 16'd1); check("ir_set_sc", {12'd0, sc_w[0]}, 16'd4);
    idle(1, 1);
    tick(0, 0, 1, 1);
    check("ic0", {15'd0, ic_w[0]}, 16'd1); check("ic0_fetch", {15'd0, f_w[0]}, 16'd0);
    idle(1, 1); check("ic1", {15'd0, ic_w[0]}, 16'd1);
    idle(1, 1); check("ic2", {15'd0, ic_w[0]}, 16'd1); check("ic2_t", t_w[0], 16'h0004);
    idle(1, 0);
    check("rt2_sc", {12'd0, sc_w[0]}, 16'd0); check("rt2_r", {15'd0, r_w[0]}, 16'd0);
    check("rt2_fetch", {15'd0, f_w[0]}, 16'd1);

    // Forced wrap: T_LIMIT 15 on A, 7 on B
    tick(0, 1, 0, 0);
    tick(1, 0, 0, 0);
    idle(7, 0);
    check("b_sc7", {12'd0, sc_w[1]}, 16'd7); check("b_werr0", {15'd0, we_w[1]}, 16'd0);
    idle(1, 0);
    check("b_wrap_sc", {12'd0, sc_w[1]}, 16'd0); check("b_wrap_werr", {15'd0, we_w[1]}, 16'd1);
    idle(7, 0);
    check("a_sc15", {12'd0, sc_w[0]}, 16'd15); check("a_t15", t_w[0], 16'h8000);
    check("a_werr0", {15'd0, we_w[0]}, 16'd0);
    idle(1, 0);
    check("a_wrap_sc", {12'd0, sc_w[0]}, 16'd0); check("a_wrap_werr", {15'd0, we_w[0]}, 16'd1);
    idle(1, 0); check("a_werr_sticky", {15'd0, we_w[0]}, 16'd1);

    // hlt beats start while stopped
    tick(0, 1, 0, 0);
    tick(1, 1, 0, 0);
    check("hlt_start_s", {15'd0, s_w[0]}, 16'd0);

    // hlt with sc_clr at RT2: halt wins, R kept pending across halt
    tick(1, 0, 0, 0);
    idle(3, 0);
    idle(1, 1);
    check("p_r", {15'd0, r_w[0]}, 16'd1);
    tick(0, 0, 1, 0);
    idle(2, 0);
    check("p_rt2", {12'd0, sc_w[0]}, 16'd2);
    tick(0, 1, 1, 0);
    check("hc_sc", {12'd0, sc_w[0]}, 16'd0); check("hc_s", {15'd0, s_w[0]}, 16'd0);
    check("hc_r", {15'd0, r_w[0]}, 16'd1);
    tick(1, 0, 0, 0);
    check("resume_ic", {15'd0, ic_w[0]}, 16'd1);

    // Reset mid-count with R set
    idle(3, 0);
    idle(3, 1);
    idle(1, 1);
    idle(5, 0);
    check("mid_sc9", {12'd0, sc_w[0]}, 16'd9); check("mid_r", {15'd0, r_w[0]}, 16'd1);
    rst = 1'b1;
    idle(1, 0);
    rst = 1'b0;
    check("mid_rst_sc", {12'd0, sc_w[0]}, 16'd0);
    check("mid_rst_flags", {12'd0, s_w[0], r_w[0], we_w[0], ic_w[0]}, 16'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
